// File: rtl/mips_pkg.sv
// Shared types for the MIPS core, its data memory and the data cache.
package mips_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;

   // Lane 0 is the leftmost (most significant) byte of the packed word.
   typedef logic [0:BYTES_PER_WORD-1][7:0] byte_lanes_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2
   } dcache_state_t;

endpackage

// File: rtl/dcache_tag_array.sv
// Valid/tag/data storage for the direct-mapped data cache: one lookup port, one write port.
module dcache_tag_array
   import mips_pkg::*;
#(
   parameter int unsigned IDX_W = 3,
   parameter int unsigned TAG_W = 27
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic [IDX_W-1:0] rd_idx,
   input  logic [TAG_W-1:0] rd_tag,
   output logic             hit,
   output byte_lanes_t      rd_data,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  byte_lanes_t      wr_data
);

   localparam int unsigned LINES = 1 << IDX_W;

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   byte_lanes_t      data_q [LINES];

   always_ff @(posedge clk) begin
      if (rst_b) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   // Tag and data need no reset: they are only observed behind a set valid bit.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_idx]  <= wr_tag;
         data_q[wr_idx] <= wr_data;
      end
   end

   assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
   assign rd_data = data_q[rd_idx];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a stalling miss/store FSM.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module data_cache
   import mips_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned LINES       = 8,
   parameter int unsigned MEM_LATENCY = 4
) (
`ifdef DCACHE_STATS_EN
   output logic [31:0]     hit_count,
   output logic [31:0]     miss_count,
`endif
   input  logic            clk,
   input  logic            rst_b,
   input  logic [XLEN-1:0] core_addr,
   input  logic            core_re,
   input  logic            core_we,
   input  byte_lanes_t     core_wdata,
   output byte_lanes_t     core_rdata,
   output logic            core_stall,
   output logic [XLEN-1:0] mem_addr,
   output byte_lanes_t     mem_data_out,
   input  byte_lanes_t     mem_data_in,
   output logic            mem_write_en
);

   localparam int unsigned IDX_W = $clog2(LINES);
   localparam int unsigned TAG_W = XLEN - 2 - IDX_W;
   localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

   dcache_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-3:0]  waddr_q, waddr_d;
   byte_lanes_t      wdata_q, wdata_d;
   logic             mem_we_q, mem_we_d;

   logic             in_idle, last;
   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             arr_hit, arr_we;
   byte_lanes_t      arr_rdata, arr_wdata;
   logic             unused_addr_bits;

   assign unused_addr_bits = ^core_addr[1:0];
   assign in_idle = (state_q == IDLE);
   assign last    = (cnt_q == CNT_LAST);

   // In IDLE the core address is looked up; in the wait states the latched one.
   assign lk_idx = in_idle ? core_addr[2 +: IDX_W] : waddr_q[IDX_W-1:0];
   assign lk_tag = in_idle ? core_addr[XLEN-1 -: TAG_W] : waddr_q[XLEN-3 -: TAG_W];

   dcache_tag_array #(
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_tag_array (
      .clk     (clk),
      .rst_b   (rst_b),
      .rd_idx  (lk_idx),
      .rd_tag  (lk_tag),
      .hit     (arr_hit),
      .rd_data (arr_rdata),
      .wr_en   (arr_we),
      .wr_idx  (waddr_q[IDX_W-1:0]),
      .wr_tag  (waddr_q[XLEN-3 -: TAG_W]),
      .wr_data (arr_wdata)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      waddr_d      = waddr_q;
      wdata_d      = wdata_q;
      mem_we_d     = mem_we_q;
      core_stall   = 1'b0;
      core_rdata   = '0;
      mem_addr     = '0;
      mem_data_out = '0;
      arr_we       = 1'b0;
      arr_wdata    = mem_data_in;
      unique case (state_q)
         IDLE: begin
            if (core_we) begin
               waddr_d    = core_addr[XLEN-1:2];
               wdata_d    = core_wdata;
               mem_we_d   = 1'b1;
               core_stall = 1'b1;
               cnt_d      = '0;
               state_d    = WR_WAIT;
            end else if (core_re) begin
               if (arr_hit) begin
                  core_rdata = arr_rdata;
               end else begin
                  waddr_d    = core_addr[XLEN-1:2];
                  core_stall = 1'b1;
                  cnt_d      = '0;
                  state_d    = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            mem_addr   = {waddr_q, 2'b00};
            core_stall = !last;
            if (last) begin
               core_rdata = mem_data_in;
               arr_we     = 1'b1;
               cnt_d      = '0;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WR_WAIT: begin
            mem_addr     = {waddr_q, 2'b00};
            mem_data_out = wdata_q;
            core_stall   = !last;
            if (last) begin
               // Write-through update only; a store miss allocates nothing.
               arr_we    = arr_hit;
               arr_wdata = wdata_q;
               mem_we_d  = 1'b0;
               cnt_d     = '0;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_b) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         mem_we_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         mem_we_q <= mem_we_d;
      end
   end

   assign mem_write_en = mem_we_q;

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk) begin
      if (rst_b) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (in_idle && !core_we && core_re && arr_hit) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
         end
         if (in_idle && (state_d == RD_WAIT)) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: a transaction-level cache/memory model predicts every response.
module tb_data_cache;
   import mips_pkg::*;

   localparam int LINES = 8;
   localparam int LAT   = 4;

   logic        clk = 1'b0;
   logic        rst_b;
   logic [31:0] core_addr;
   logic        core_re, core_we;
   byte_lanes_t core_wdata, core_rdata, mem_data_out, mem_data_in;
   logic        core_stall, mem_write_en;
   logic [31:0] mem_addr;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   always #5 clk = ~clk;

   data_cache #(
      .XLEN        (32),
      .LINES       (LINES),
      .MEM_LATENCY (LAT)
   ) dut (
`ifdef DCACHE_STATS_EN
      .hit_count    (hit_count),
      .miss_count   (miss_count),
`endif
      .clk          (clk),
      .rst_b        (rst_b),
      .core_addr    (core_addr),
      .core_re      (core_re),
      .core_we      (core_we),
      .core_wdata   (core_wdata),
      .core_rdata   (core_rdata),
      .core_stall   (core_stall),
      .mem_addr     (mem_addr),
      .mem_data_out (mem_data_out),
      .mem_data_in  (mem_data_in),
      .mem_write_en (mem_write_en)
   );

   // Device memory (driven by the DUT) and the model's view of what memory should hold.
   byte_lanes_t dev_mem [0:1023];
   byte_lanes_t ref_mem [0:1023];
   int          resident [LINES];
   int          ref_hits = 0;
   int          ref_misses = 0;
   int          total = 0;
   int          bad = 0;

   assign mem_data_in = dev_mem[mem_addr[11:2]];

   always @(posedge clk) begin
      if (mem_write_en) dev_mem[mem_addr[11:2]] <= mem_data_out;
   end

   typedef struct {
      bit          is_store;
      byte_lanes_t rdata;
      int          stalls;
      int          wecyc;
      logic [31:0] waddr;
      byte_lanes_t wdata;
      logic [31:0] reqaddr;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int lidx(input logic [31:0] a);
      return int'(a[11:2]) % LINES;
   endfunction

   // Monitor: counts stall and write-strobe cycles, compares on each completed request.
   int          st_cnt = 0;
   int          we_cnt = 0;
   logic [31:0] we_addr = '0;
   byte_lanes_t we_data = '0;
   exp_t        mon_e;

   always @(negedge clk) begin
      if (rst_b) begin
         st_cnt = 0;
         we_cnt = 0;
      end else begin
         if (mem_write_en) begin
            we_cnt++;
            we_addr = mem_addr;
            we_data = mem_data_out;
         end
         if (core_re || core_we) begin
            if (core_stall) begin
               st_cnt++;
            end else begin
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_completion: addr %0h with empty scoreboard", core_addr);
               end else begin
                  mon_e = sb.pop_front();
                  check("stall_cycles", 64'(st_cnt), 64'(mon_e.stalls));
                  check("write_en_cycles", 64'(we_cnt), 64'(mon_e.wecyc));
                  if (mon_e.is_store) begin
                     check("store_mem_addr", 64'(we_addr), 64'(mon_e.waddr));
                     check("store_mem_data", 64'(we_data), 64'(mon_e.wdata));
                  end else begin
                     check("load_rdata", 64'(core_rdata), 64'(mon_e.rdata));
                  end
               end
               st_cnt = 0;
               we_cnt = 0;
            end
         end
      end
   end

   task automatic finish_req();
      int n = 0;
      forever begin
         @(negedge clk);
         if (!core_stall) break;
         n++;
         if (n > 20) begin
            $display("FAIL stall_timeout: addr %0h still stalled after %0d cycles", core_addr, n);
            $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
            $fatal(1);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [31:0] a);
      exp_t e;
      int   i = lidx(a);
      int   w = int'(a[11:2]);
      e.is_store = 1'b0;
      e.rdata    = ref_mem[w];
      e.wecyc    = 0;
      e.waddr    = '0;
      e.wdata    = '0;
      e.reqaddr  = a;
      if (resident[i] == w) begin
         e.stalls = 0;
         ref_hits++;
      end else begin
         e.stalls = LAT;
         ref_misses++;
         resident[i] = w;
      end
      sb.push_back(e);
      core_addr = a;
      core_re   = 1'b1;
      core_we   = 1'b0;
      finish_req();
      core_re = 1'b0;
   endtask

   task automatic do_store(input logic [31:0] a, input byte_lanes_t d, input bit with_re);
      exp_t e;
      int   w = int'(a[11:2]);
      e.is_store = 1'b1;
      e.rdata    = '0;
      e.stalls   = LAT;
      e.wecyc    = LAT;
      e.waddr    = {a[31:2], 2'b00};
      e.wdata    = d;
      e.reqaddr  = a;
      ref_mem[w] = d;
      sb.push_back(e);
      core_addr  = a;
      core_wdata = d;
      core_re    = with_re;
      core_we    = 1'b1;
      finish_req();
      core_re = 1'b0;
      core_we = 1'b0;
   endtask

   task automatic idle_cycle();
      core_re = 1'b0;
      core_we = 1'b0;
      core_addr = $urandom;
      @(negedge clk);
      check("idle_stall", 64'(core_stall), 64'(0));
      check("idle_rdata", 64'(core_rdata), 64'(0));
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] a;
      byte_lanes_t d;
      int          r;
      rst_b      = 1'b1;
      core_re    = 1'b0;
      core_we    = 1'b0;
      core_addr  = '0;
      core_wdata = '0;
      for (int i = 0; i < 1024; i++) begin
         dev_mem[i] = $urandom;
         ref_mem[i] = dev_mem[i];
      end
      dev_mem[64] = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
      ref_mem[64] = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
      foreach (resident[i]) resident[i] = -1;

      repeat (2) @(posedge clk);
      #1 rst_b = 1'b0;
      @(negedge clk);
      check("reset_stall", 64'(core_stall), 64'(0));
      check("reset_mem_we", 64'(mem_write_en), 64'(0));
      check("reset_mem_addr", 64'(mem_addr), 64'(0));
      check("reset_mem_data_out", 64'(mem_data_out), 64'(0));
      check("reset_rdata", 64'(core_rdata), 64'(0));
`ifdef DCACHE_STATS_EN
      check("reset_hit_count", 64'(hit_count), 64'(0));
      check("reset_miss_count", 64'(miss_count), 64'(0));
`endif
      @(posedge clk);
      #1;

      do_load(32'h100);
      do_load(32'h100);
      do_load(32'h120);
      do_load(32'h100);
      do_store(32'h100, {8'd1, 8'd2, 8'd3, 8'd4}, 1'b0);
      do_load(32'h100);
      do_store(32'h200, {8'h55, 8'h66, 8'h77, 8'h88}, 1'b0);
      do_load(32'h200);
      do_store(32'h104, {8'hA1, 8'hB2, 8'hC3, 8'hD4}, 1'b1);
      idle_cycle();

      // Reset in the second RD_WAIT cycle of a miss aborts it without filling the line.
      core_addr = 32'h344;
      core_re   = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_b   = 1'b1;
      core_re = 1'b0;
      @(posedge clk);
      #1;
      rst_b = 1'b0;
      foreach (resident[i]) resident[i] = -1;
      ref_hits   = 0;
      ref_misses = 0;
      @(negedge clk);
      check("abort_stall", 64'(core_stall), 64'(0));
      check("abort_mem_we", 64'(mem_write_en), 64'(0));
`ifdef DCACHE_STATS_EN
      check("abort_hit_count", 64'(hit_count), 64'(0));
      check("abort_miss_count", 64'(miss_count), 64'(0));
`endif
      @(posedge clk);
      #1;
      do_load(32'h344);
      do_load(32'h344);

      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         a = ({30'd0, 2'($urandom_range(0, 3))} << 8) | ({29'd0, 3'($urandom_range(0, 7))} << 2)
             | 32'($urandom_range(0, 3));
         d = $urandom;
         if (r <= 4) do_load(a);
         else if (r <= 7) do_store(a, d, 1'b0);
         else if (r == 8) do_store(a, d, 1'b1);
         else idle_cycle();
      end

      @(negedge clk);
      check("scoreboard_drained", 64'(sb.size()), 64'(0));
`ifdef DCACHE_STATS_EN
      check("final_hit_count", 64'(hit_count), 64'(ref_hits));
      check("final_miss_count", 64'(miss_count), 64'(ref_misses));
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
